alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin sequencer in front of one shared
// combinational ALU. One operation in flight: IDLE -> EXEC -> RESP -> IDLE.

// Per-requester response holding register.
module alu_arbiter_rsp #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cap,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] d_result,
  input  logic                  d_zero,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);

  // Capture the ALU output on EXEC; drop valid on the response handshake.
  // Data is left in place after the handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid  <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
    end else if (cap) begin
      valid  <= 1'b1;
      result <= d_result;
      zero   <= d_zero;
    end else if (clr) begin
      valid  <= 1'b0;
    end
  end

endmodule

module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [3:0]            req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [4:0]            req0_shamt,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [3:0]            req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [4:0]            req1_shamt,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_result,
  output logic                  rsp0_zero,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_result,
  output logic                  rsp1_zero,
  output logic [3:0]            alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [5:0]            alu_shamt,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   cur;
  logic   last_grant;
  logic   any_valid;
  logic   gnt;

  logic [1:0]                 rsp_ready_v;
  logic [1:0]                 rsp_valid_v;
  logic [1:0][DATA_WIDTH-1:0] rsp_result_v;
  logic [1:0]                 rsp_zero_v;
  logic [1:0]                 cur_oh;

  // Grant: sole requester wins; on a tie the one not served last wins.
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    gnt        = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    req0_ready = reset & (state == IDLE) & req0_valid & ~gnt;
    req1_ready = reset & (state == IDLE) & req1_valid &  gnt;
  end

  assign busy        = (state != IDLE);
  assign cur_oh      = {cur, ~cur};
  assign rsp_ready_v = {rsp1_ready, rsp0_ready};

  // Sequencer: load ALU operands on accept, one EXEC cycle, hold in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cur        <= 1'b0;
      last_grant <= 1'b1;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_shamt  <= '0;
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          cur       <= gnt;
          alu_op    <= gnt ? req1_op : req0_op;
          alu_a     <= gnt ? req1_a  : req0_a;
          alu_b     <= gnt ? req1_b  : req0_b;
          alu_shamt <= {1'b0, gnt ? req1_shamt : req0_shamt};
          state     <= EXEC;
        end
        EXEC: state <= RESP;
        RESP: if (rsp_ready_v[cur]) begin
          last_grant <= cur;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_rsp
    alu_arbiter_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp (
      .clk      (clk),
      .reset    (reset),
      .cap      ((state == EXEC) & cur_oh[g]),
      .clr      ((state == RESP) & cur_oh[g] & rsp_ready_v[g]),
      .d_result (alu_result),
      .d_zero   (alu_zero),
      .valid    (rsp_valid_v[g]),
      .result   (rsp_result_v[g]),
      .zero     (rsp_zero_v[g])
    );
  end

  assign rsp0_valid  = rsp_valid_v[0];
  assign rsp0_result = rsp_result_v[0];
  assign rsp0_zero   = rsp_zero_v[0];
  assign rsp1_valid  = rsp_valid_v[1];
  assign rsp1_result = rsp_result_v[1];
  assign rsp1_zero   = rsp_zero_v[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* ports.
module tb_alu_arbiter;

  logic        clk, reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        rsp0_valid, rsp0_ready, rsp0_zero;
  logic        rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [5:0]  alu_shamt;
  logic        alu_zero, busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU behaviour.
  always_comb begin
    case (alu_op)
      4'd0:    alu_result = alu_a & alu_b;
      4'd1:    alu_result = alu_a | alu_b;
      4'd2:    alu_result = ~(alu_a | alu_b);
      4'd3:    alu_result = alu_a + alu_b;
      4'd4:    alu_result = alu_a - alu_b;
      4'd5:    alu_result = alu_b << alu_shamt[4:0];
      4'd6:    alu_result = alu_b >> alu_shamt[4:0];
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] sh);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_shamt = sh;
  endtask

  task automatic set1(input logic v, input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] sh);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_shamt = sh;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int n0, n1, exp_g;
    reset = 1'b0;
    set0(1'b1, 4'd3, 32'd5, 32'd7, 5'd0);
    set1(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #2;
    // Reset state; ready held low while reset is asserted even with valid high.
    chkb("rst_req0_ready", req0_ready, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk("rst_rsp0_result", rsp0_result, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_shamt", 32'(alu_shamt), 32'd0);
    tick();
    reset = 1'b1;
    #1;

    // Single op: ADD 5+7.
    chkb("single_req0_ready", req0_ready, 1'b1);
    chkb("single_req1_ready", req1_ready, 1'b0);
    tick();
    set0(1'b0, 4'd3, 32'd5, 32'd7, 5'd0);
    chk("single_alu_op", 32'(alu_op), 32'd3);
    chk("single_alu_a", alu_a, 32'd5);
    chkb("single_busy", busy, 1'b1);
    chkb("single_rsp0_early", rsp0_valid, 1'b0);
    tick();
    chkb("single_rsp0_valid", rsp0_valid, 1'b1);
    chk("single_result", rsp0_result, 32'd12);
    chkb("single_zero", rsp0_zero, 1'b0);
    chkb("single_rsp1_valid", rsp1_valid, 1'b0);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    chkb("single_rsp0_clr", rsp0_valid, 1'b0);
    chkb("single_idle", busy, 1'b0);

    // Tie after reset: req0 wins, req1 accepted right after the handshake.
    do_reset();
    set0(1'b1, 4'd4, 32'd9, 32'd9, 5'd0);
    set1(1'b1, 4'd1, 32'hF0, 32'h0F, 5'd0);
    #1;
    chkb("tie_req0_ready", req0_ready, 1'b1);
    chkb("tie_req1_ready", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    #1;
    chkb("tie_exec_req1_ready", req1_ready, 1'b0);
    tick();
    chkb("tie_rsp0_valid", rsp0_valid, 1'b1);
    chk("tie_rsp0_result", rsp0_result, 32'd0);
    chkb("tie_rsp0_zero", rsp0_zero, 1'b1);
    chkb("tie_resp_req1_ready", req1_ready, 1'b0);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    chkb("tie_req1_ready_after", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    tick();
    chkb("tie_rsp1_valid", rsp1_valid, 1'b1);
    chk("tie_rsp1_result", rsp1_result, 32'hFF);
    chkb("tie_rsp1_zero", rsp1_zero, 1'b0);
    chkb("tie_rsp0_untouched", rsp0_valid, 1'b0);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;
    chkb("tie_rsp1_clr", rsp1_valid, 1'b0);

    // Fairness: both valid throughout, 4 ops each; last served was req1.
    n0 = 0; n1 = 0;
    set0(1'b1, 4'd3, 32'(n0), 32'h0, 5'd0);
    set1(1'b1, 4'd3, 32'(n1), 32'h100, 5'd0);
    for (int k = 0; k < 8; k++) begin
      exp_g = k % 2;
      #1;
      chkb("fair_req0_ready", req0_ready, exp_g == 0);
      chkb("fair_req1_ready", req1_ready, exp_g == 1);
      tick();
      if (exp_g == 0) begin n0++; req0_a = 32'(n0); if (n0 == 4) req0_valid = 1'b0; end
      else            begin n1++; req1_a = 32'(n1); if (n1 == 4) req1_valid = 1'b0; end
      tick();
      if (exp_g == 0) begin
        chkb("fair_rsp0_valid", rsp0_valid, 1'b1);
        chk("fair_rsp0_result", rsp0_result, 32'(n0 - 1));
        chkb("fair_rsp1_idle", rsp1_valid, 1'b0);
        rsp0_ready = 1'b1;
      end else begin
        chkb("fair_rsp1_valid", rsp1_valid, 1'b1);
        chk("fair_rsp1_result", rsp1_result, 32'h100 + 32'(n1 - 1));
        chkb("fair_rsp0_idle", rsp0_valid, 1'b0);
        rsp1_ready = 1'b1;
      end
      tick();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    end

    // Shifts on req1 across the full shift range.
    set1(1'b1, 4'd5, 32'd0, 32'h1, 5'd31);
    tick();
    req1_valid = 1'b0;
    chk("sll_alu_shamt", 32'(alu_shamt), 32'd31);
    tick();
    chk("sll_result", rsp1_result, 32'h8000_0000);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;
    set1(1'b1, 4'd6, 32'd0, 32'h8000_0000, 5'd31);
    tick();
    req1_valid = 1'b0;
    chk("srl_alu_shamt", 32'(alu_shamt), 32'd31);
    tick();
    chk("srl_result", rsp1_result, 32'h1);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;

    // Unsupported op code passes through and yields zero.
    set0(1'b1, 4'd9, 32'h1234, 32'h5678, 5'd0);
    tick();
    req0_valid = 1'b0;
    chk("badop_alu_op", 32'(alu_op), 32'd9);
    tick();
    chk("badop_result", rsp0_result, 32'd0);
    chkb("badop_zero", rsp0_zero, 1'b1);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;

    // Backpressure on rsp0 with req1 waiting.
    set0(1'b1, 4'd3, 32'd1, 32'd2, 5'd0);
    tick();
    req0_valid = 1'b0;
    set1(1'b1, 4'd0, 32'hA, 32'hB, 5'd0);
    tick();
    for (int s = 0; s < 5; s++) begin
      chkb("bp_rsp0_valid", rsp0_valid, 1'b1);
      chk("bp_result", rsp0_result, 32'd3);
      chkb("bp_busy", busy, 1'b1);
      chkb("bp_req1_ready", req1_ready, 1'b0);
      tick();
    end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    chkb("bp_release_busy", busy, 1'b0);
    chkb("bp_release_req1_ready", req1_ready, 1'b1);
    req1_valid = 1'b0;
    tick();

    // Reset in RESP drops the transaction immediately.
    set0(1'b1, 4'd3, 32'd4, 32'd4, 5'd0);
    tick();
    req0_valid = 1'b0;
    tick();
    chkb("mid_rsp0_valid", rsp0_valid, 1'b1);
    reset = 1'b0;
    #1;
    chkb("mid_rst_rsp0_valid", rsp0_valid, 1'b0);
    chkb("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    tick();
    reset = 1'b1;
    set1(1'b1, 4'd0, 32'hFF, 32'h0F, 5'd0);
    #1;
    chkb("post_req1_ready", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    chkb("post_rsp0_quiet", rsp0_valid, 1'b0);
    tick();
    chkb("post_rsp1_valid", rsp1_valid, 1'b1);
    chk("post_rsp1_result", rsp1_result, 32'h0F);
    chkb("post_rsp0_none", rsp0_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
